// File: rtl/spiregs_v2_if.sv
// SPI message bus carrying one completed command frame from the deframer into the register block.
// Latency: none, wires only.
// Backpressure: none; the deframer strobes spi_msg_end once per message and the block always accepts it.
// Ports: spi_msg_end (1-cycle strobe), spi_cmd (command byte), spi_rxdata (64-bit payload, first byte in [63:56]).
interface spiregs_v2_if;
    logic        spi_msg_end;
    logic [7:0]  spi_cmd;
    logic [63:0] spi_rxdata;

    modport master (output spi_msg_end, output spi_cmd, output spi_rxdata);
    modport slave  (input  spi_msg_end, input  spi_cmd, input  spi_rxdata);
endinterface

// File: rtl/spiregs_v2.sv
// SPI command register block: decodes SPI messages into system controls and a keyboard-character FIFO.
// Latency: register results are visible 1 cycle after spi_msg_end; FIFO head is first-word-fall-through.
// Backpressure: none; a push into a full FIFO (without a same-cycle pop) is dropped and sets sticky overflow.
// Ports: clk, reset_n (async active-low), spi (spiregs_v2_if.slave), reset_req, keys, hctrl,
//        kbbuf_rddata/rden/empty/full/count/overflow, use_t80, has_z80, force_turbo, video_mode.
// Optional: define SPIREGS_KBBUF_BURST_EN to add command 14h (multi-byte FIFO push driven by a small FSM).
module spiregs_v2 #(
    parameter int NUM_HCTRL          = 2,
    parameter int KBBUF_DEPTH        = 16,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int VIDMODE_BITS       = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    spiregs_v2_if.slave                   spi,
    output logic                          reset_req,
    output logic [63:0]                   keys,
    output logic [8*NUM_HCTRL-1:0]        hctrl,
    output logic [7:0]                    kbbuf_rddata,
    input  logic                          kbbuf_rden,
    output logic                          kbbuf_empty,
    output logic                          kbbuf_full,
    output logic [$clog2(KBBUF_DEPTH):0]  kbbuf_count,
    output logic                          kbbuf_overflow,
    output logic                          use_t80,
    input  logic                          has_z80,
    output logic                          force_turbo,
    output logic [VIDMODE_BITS-1:0]       video_mode
);
    localparam int AW = $clog2(KBBUF_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] CMD_RESET       = 8'h01;
    localparam logic [7:0] CMD_FORCE_TURBO = 8'h02;
    localparam logic [7:0] CMD_SET_KEYB    = 8'h10;
    localparam logic [7:0] CMD_SET_HCTRL   = 8'h11;
    localparam logic [7:0] CMD_WRITE_KBBUF = 8'h12;
    localparam logic [7:0] CMD_CLEAR_KBBUF = 8'h13;
    localparam logic [7:0] CMD_SET_VIDMODE = 8'h40;

    logic [63:0] rx;
    logic        is_reset, is_turbo, is_keyb, is_hctrl, is_write, is_clear, is_vid;

    assign rx       = spi.spi_rxdata;
    assign is_reset = spi.spi_msg_end && (spi.spi_cmd == CMD_RESET);
    assign is_turbo = spi.spi_msg_end && (spi.spi_cmd == CMD_FORCE_TURBO);
    assign is_keyb  = spi.spi_msg_end && (spi.spi_cmd == CMD_SET_KEYB);
    assign is_hctrl = spi.spi_msg_end && (spi.spi_cmd == CMD_SET_HCTRL);
    assign is_write = spi.spi_msg_end && (spi.spi_cmd == CMD_WRITE_KBBUF);
    assign is_clear = spi.spi_msg_end && (spi.spi_cmd == CMD_CLEAR_KBBUF);
    assign is_vid   = spi.spi_msg_end && (spi.spi_cmd == CMD_SET_VIDMODE);

    // Persistent state deliberately has no reset_n term: reset_req may be wired back into reset_n,
    // and the pulse and CPU/video mode selection must survive that loop. Values below are power-up only.
    logic                    q_use_t80    = 1'b0;
    logic [VIDMODE_BITS-1:0] video_mode_q = '0;
    logic [7:0]              rst_cnt      = 8'd0;

    always_ff @(posedge clk) begin
        if (is_reset) begin
            q_use_t80 <= rx[56];
            rst_cnt   <= 8'(RESET_PULSE_CYCLES);
        end else if (rst_cnt != 8'd0) begin
            rst_cnt <= rst_cnt - 8'd1;
        end
        if (is_vid) begin
            video_mode_q <= rx[56 +: VIDMODE_BITS];
        end
    end

    // Counter is loaded on the strobe edge, so reset_req is high for exactly RESET_PULSE_CYCLES cycles.
    assign reset_req  = (rst_cnt != 8'd0);
    assign video_mode = video_mode_q;
    assign use_t80    = has_z80 ? q_use_t80 : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys        <= '1;
            hctrl       <= '1;
            force_turbo <= 1'b0;
        end else begin
            if (is_keyb) begin
                keys <= rx;
            end
            if (is_turbo) begin
                force_turbo <= rx[56];
            end
            if (is_hctrl) begin
                // Controller 1 takes the first payload byte, controller 2 the second, and so on.
                for (int i = 0; i < NUM_HCTRL; i++) begin
                    hctrl[8*i +: 8] <= rx[63-8*i -: 8];
                end
            end
        end
    end

    // FIFO push sources: the single-byte command, or the burst engine when it is built.
    logic       push_req;
    logic [7:0] push_byte;
    logic       cmd_drop;

`ifdef SPIREGS_KBBUF_BURST_EN
    localparam logic [7:0] CMD_WRITE_BURST = 8'h14;

    typedef enum logic {ST_IDLE, ST_PUSH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  left_q;
    logic [55:0] bdata_q;
    logic        is_burst;
    logic        burst_push;

    assign is_burst = spi.spi_msg_end && (spi.spi_cmd == CMD_WRITE_BURST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        burst_push = 1'b0;
        cmd_drop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_burst && (rx[58:56] != 3'd0)) begin
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (is_clear) begin
                    state_d = ST_IDLE;
                end else begin
                    burst_push = 1'b1;
                    // Only one push per cycle: any new write command arriving mid-burst is lost.
                    cmd_drop   = is_write || is_burst;
                    if (left_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Payload is captured at the strobe and shifted out MSB-byte first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_q  <= 3'd0;
            bdata_q <= '0;
        end else if ((state_q == ST_IDLE) && is_burst) begin
            left_q  <= rx[58:56];
            bdata_q <= rx[55:0];
        end else if (burst_push) begin
            left_q  <= left_q - 3'd1;
            bdata_q <= {bdata_q[47:0], 8'h00};
        end
    end

    assign push_req  = burst_push || (is_write && (state_q == ST_IDLE));
    assign push_byte = burst_push ? bdata_q[55:48] : rx[63:56];
`else
    assign push_req  = is_write;
    assign push_byte = rx[63:56];
    assign cmd_drop  = 1'b0;
`endif

    logic [7:0]    mem [KBBUF_DEPTH];
    logic [AW-1:0] wrptr, rdptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          pop, push_ok;

    assign kbbuf_empty    = (count_q == '0);
    assign kbbuf_full     = (count_q == CW'(KBBUF_DEPTH));
    assign kbbuf_count    = count_q;
    assign kbbuf_overflow = overflow_q;
    assign kbbuf_rddata   = mem[rdptr];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign pop     = kbbuf_rden && !kbbuf_empty;
    assign push_ok = push_req && !is_clear && (!kbbuf_full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrptr      <= '0;
            rdptr      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (is_clear) begin
            wrptr      <= '0;
            rdptr      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wrptr <= wrptr + AW'(1);
            end
            if (pop) begin
                rdptr <= rdptr + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            if ((push_req && !push_ok) || cmd_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wrptr] <= push_byte;
        end
    end
endmodule

// File: tb/tb_spiregs_v2.sv
// Testbench for spiregs_v2: randomized and directed command stimulus against a queue-based reference model.
// Latency: the model is updated as each cycle is driven; register checks follow the active edge by 1 time unit.
// Backpressure: a monitor pops the expected FIFO bytes whenever the DUT presents a pop.
module tb_spiregs_v2;
    localparam int DEPTH = 16;
    localparam int NH    = 2;
    localparam int RP    = 16;
    localparam int VB    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n_drv;
    logic                     loop_en;
    logic                     reset_n;
    logic                     reset_req;
    logic [63:0]              keys;
    logic [8*NH-1:0]          hctrl;
    logic [7:0]               kbbuf_rddata;
    logic                     kbbuf_rden;
    logic                     kbbuf_empty;
    logic                     kbbuf_full;
    logic [$clog2(DEPTH):0]   kbbuf_count;
    logic                     kbbuf_overflow;
    logic                     use_t80;
    logic                     has_z80;
    logic                     force_turbo;
    logic [VB-1:0]            video_mode;

    spiregs_v2_if spi_if ();

    assign reset_n = rst_n_drv & ~(loop_en & reset_req);

    spiregs_v2 #(
        .NUM_HCTRL          (NH),
        .KBBUF_DEPTH        (DEPTH),
        .RESET_PULSE_CYCLES (RP),
        .VIDMODE_BITS       (VB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi            (spi_if),
        .reset_req      (reset_req),
        .keys           (keys),
        .hctrl          (hctrl),
        .kbbuf_rddata   (kbbuf_rddata),
        .kbbuf_rden     (kbbuf_rden),
        .kbbuf_empty    (kbbuf_empty),
        .kbbuf_full     (kbbuf_full),
        .kbbuf_count    (kbbuf_count),
        .kbbuf_overflow (kbbuf_overflow),
        .use_t80        (use_t80),
        .has_z80        (has_z80),
        .force_turbo    (force_turbo),
        .video_mode     (video_mode)
    );

    int ncheck = 0;
    int nerr   = 0;

    // Reference model state
    logic [63:0]   m_keys;
    logic [8*NH-1:0] m_hctrl;
    bit            m_turbo;
    logic [VB-1:0] m_vid;
    bit            m_qt80;
    bit            m_ovf;
    logic [7:0]    mq[$];     // FIFO contents
    logic [7:0]    pend[$];   // burst bytes still to be pushed
    logic [7:0]    sb_q[$];   // expected bytes for the monitor

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (kbbuf_rden && !kbbuf_empty) begin
                if (sb_q.size() == 0) begin
                    ncheck++;
                    nerr++;
                    $display("FAIL pop_unexpected: got %h with no byte expected", kbbuf_rddata);
                end else begin
                    e = sb_q.pop_front();
                    chk("pop_data", {56'h0, kbbuf_rddata}, {56'h0, e});
                end
            end
        end
    endtask

    // Drive one clock cycle of inputs and advance the model by the same cycle.
    task automatic cycle(input bit msg, input logic [7:0] cmd, input logic [63:0] data, input bit rd);
        bit         busy;
        bit         do_pop;
        bit         do_push;
        bit         clr;
        logic [7:0] pb;
        spi_if.spi_msg_end = msg;
        spi_if.spi_cmd     = cmd;
        spi_if.spi_rxdata  = data;
        kbbuf_rden         = rd;

        busy    = (pend.size() > 0);
        do_pop  = rd && (mq.size() > 0);
        do_push = 1'b0;
        clr     = msg && (cmd == 8'h13);
        pb      = 8'h00;
        if (do_pop) sb_q.push_back(mq[0]);
        if (busy && !clr) begin
            do_push = 1'b1;
            pb      = pend.pop_front();
        end
        if (msg) begin
            case (cmd)
                8'h01: m_qt80  = data[56];
                8'h02: m_turbo = data[56];
                8'h10: m_keys  = data;
                8'h11: for (int i = 0; i < NH; i++) m_hctrl[8*i +: 8] = data[63-8*i -: 8];
                8'h12: begin
                    if (busy) m_ovf = 1'b1;
                    else begin
                        do_push = 1'b1;
                        pb      = data[63:56];
                    end
                end
                8'h14: begin
`ifdef SPIREGS_KBBUF_BURST_EN
                    if (busy) m_ovf = 1'b1;
                    else for (int k = 0; k < int'(data[58:56]); k++) pend.push_back(data[55-8*k -: 8]);
`endif
                end
                8'h40: m_vid = data[56 +: VB];
                default: ;
            endcase
        end
        if (clr) begin
            mq.delete();
            pend.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(pb);
                else m_ovf = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        spi_if.spi_msg_end = 1'b0;
        kbbuf_rden         = 1'b0;
    endtask

    task automatic check_fifo(input string tag);
        chk({tag, " count"},    {59'h0, kbbuf_count}, 64'(mq.size()));
        chk({tag, " empty"},    {63'h0, kbbuf_empty}, {63'h0, mq.size() == 0});
        chk({tag, " full"},     {63'h0, kbbuf_full},  {63'h0, mq.size() == DEPTH});
        chk({tag, " overflow"}, {63'h0, kbbuf_overflow}, {63'h0, m_ovf});
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " keys"},  keys, m_keys);
        chk({tag, " hctrl"}, 64'(hctrl), 64'(m_hctrl));
        chk({tag, " turbo"}, {63'h0, force_turbo}, {63'h0, m_turbo});
        chk({tag, " vid"},   64'(video_mode), 64'(m_vid));
        chk({tag, " t80"},   {63'h0, use_t80}, {63'h0, (has_z80 ? m_qt80 : 1'b1)});
    endtask

    task automatic pulse_test(input string tag);
        int first;
        int len;
        first = 0;
        len   = 0;
        cycle(1'b1, 8'h01, 64'h0100_0000_0000_0000, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (reset_req) begin
                len++;
                if (first == 0) first = i;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " first"}, 64'(first), 64'd1);
        chk({tag, " len"},   64'(len),   64'(RP));
        chk({tag, " t80"},   {63'h0, use_t80}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int         b;
        int         r;
        int         guard;
        logic [7:0] c;
        logic [63:0] d;
        rst_n_drv          = 1'b0;
        loop_en            = 1'b0;
        has_z80            = 1'b1;
        kbbuf_rden         = 1'b0;
        spi_if.spi_msg_end = 1'b0;
        spi_if.spi_cmd     = 8'h00;
        spi_if.spi_rxdata  = 64'h0;
        m_keys  = '1;
        m_hctrl = '1;
        m_turbo = 1'b0;
        m_vid   = '0;
        m_qt80  = 1'b0;
        m_ovf   = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst keys",  keys, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst hctrl", 64'(hctrl), 64'hFFFF);
        chk("rst empty", {63'h0, kbbuf_empty}, 64'd1);
        chk("rst count", {59'h0, kbbuf_count}, 64'd0);
        chk("rst reset_req", {63'h0, reset_req}, 64'd0);
        rst_n_drv = 1'b1;
        @(posedge clk);
        #1;
        check_regs("post_rst");
        check_fifo("post_rst");

        cycle(1'b1, 8'h10, {$urandom, $urandom}, 1'b0);
        check_regs("keys");
        cycle(1'b1, 8'h11, 64'hAB12_3456_789A_BCDE, 1'b0);
        chk("hctrl_ab12", 64'(hctrl), 64'h12AB);
        cycle(1'b1, 8'h02, 64'h0100_0000_0000_0000, 1'b0);
        check_regs("turbo");
        cycle(1'b1, 8'h40, 64'h0100_0000_0000_0000, 1'b0);
        chk("vid_one", 64'(video_mode), 64'd1);
        cycle(1'b1, 8'h77, {$urandom, $urandom}, 1'b0);
        check_regs("unknown");

        pulse_test("pulse");
        cycle(1'b1, 8'h12, 64'hAA00_0000_0000_0000, 1'b0);
        cycle(1'b1, 8'h12, 64'hBB00_0000_0000_0000, 1'b0);
        check_fifo("pre_loop");
        loop_en = 1'b1;
        pulse_test("loop_pulse");
        loop_en = 1'b0;
        m_keys  = '1;
        m_hctrl = '1;
        m_turbo = 1'b0;
        mq.delete();
        m_ovf   = 1'b0;
        check_regs("post_loop");
        check_fifo("post_loop");

        has_z80 = 1'b0;
        #1;
        chk("noz80 t80", {63'h0, use_t80}, 64'd1);
        cycle(1'b1, 8'h01, 64'h0, 1'b0);
        check_regs("noz80_reset0");
        has_z80 = 1'b1;
        #1;
        check_regs("z80_reset0");
        repeat (RP + 2) cycle(1'b0, 8'h00, 64'h0, 1'b0);

        for (b = 0; b <= DEPTH; b++) begin
            d = {8'(b), 56'h0};
            cycle(1'b1, 8'h12, d, 1'b0);
            check_fifo("fill");
        end
        chk("fill full", {63'h0, kbbuf_full}, 64'd1);
        chk("fill ovf",  {63'h0, kbbuf_overflow}, 64'd1);
        for (b = 0; b < DEPTH; b++) cycle(1'b0, 8'h00, 64'h0, 1'b1);
        check_fifo("drained");
        cycle(1'b0, 8'h00, 64'h0, 1'b1);
        check_fifo("pop_empty");
        cycle(1'b1, 8'h13, 64'h0, 1'b0);
        chk("clear ovf", {63'h0, kbbuf_overflow}, 64'd0);

        for (b = 0; b < DEPTH - 1; b++) cycle(1'b1, 8'h12, {8'(b + 8'h20), 56'h0}, 1'b0);
        cycle(1'b1, 8'h12, 64'h5500_0000_0000_0000, 1'b1);
        check_fifo("pushpop_d1");
        cycle(1'b1, 8'h12, 64'h6600_0000_0000_0000, 1'b0);
        check_fifo("now_full");
        cycle(1'b1, 8'h12, 64'h7700_0000_0000_0000, 1'b1);
        check_fifo("pushpop_full");
        for (b = 0; b < DEPTH; b++) cycle(1'b0, 8'h00, 64'h0, 1'b1);
        check_fifo("drain2");
        for (b = 0; b < 3; b++) cycle(1'b1, 8'h12, {8'(b), 56'h0}, 1'b0);
        cycle(1'b1, 8'h13, 64'h0, 1'b1);
        check_fifo("clear_pop");

        cycle(1'b1, 8'h14, 64'h0341_4243_0000_0000, 1'b0);
        for (b = 0; b < 4; b++) begin
            cycle(1'b0, 8'h00, 64'h0, 1'b0);
            check_fifo("burst");
        end
        for (b = 0; b < 3; b++) cycle(1'b0, 8'h00, 64'h0, 1'b1);
        cycle(1'b1, 8'h14, 64'h0701_0203_0405_0607, 1'b0);
        cycle(1'b1, 8'h12, 64'h9900_0000_0000_0000, 1'b0);
        check_fifo("burst_drop");
        cycle(1'b1, 8'h13, 64'h0, 1'b0);
        check_fifo("burst_abort");
        repeat (3) cycle(1'b0, 8'h00, 64'h0, 1'b0);
        check_fifo("burst_idle");

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            d = {$urandom, $urandom};
            if (r < 40)      c = 8'h12;
            else if (r < 46) c = 8'h13;
            else if (r < 56) c = 8'h14;
            else if (r < 60) c = 8'h10;
            else if (r < 64) c = 8'h11;
            else if (r < 67) c = 8'h02;
            else if (r < 70) c = 8'h40;
            else if (r < 72) c = 8'h01;
            else             c = 8'h55;
            cycle($urandom_range(0, 99) < 60, c, d, $urandom_range(0, 99) < 40);
            check_fifo("rand");
            check_regs("rand");
        end

        guard = 0;
        while ((mq.size() > 0 || pend.size() > 0) && guard < 100) begin
            cycle(1'b0, 8'h00, 64'h0, 1'b1);
            guard++;
        end
        chk("drain_bound", 64'(guard < 100), 64'd1);
        cycle(1'b0, 8'h00, 64'h0, 1'b0);
        check_fifo("final");
        chk("scoreboard_left", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
        $finish;
    end
endmodule
